// File: rtl/beat_timebase.sv
// rtl/beat_timebase.sv - game timebase: prescaled base_tick, seconds counter, NUM_CH beat channels
// Optional BEAT_FAST_FWD_EN adds fast_fwd input that halves the prescaler terminal count.
module beat_timebase #(
    parameter int PRESCALE = 50_000_000,
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 16,
    parameter int SEC_W    = 16,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              is_game,
    input  logic              is_open,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic              cfg_oneshot,
    input  logic [NUM_CH-1:0] ch_en,
`ifdef BEAT_FAST_FWD_EN
    input  logic              fast_fwd,
`endif
    output logic              base_tick,
    output logic [SEC_W-1:0]  seconds,
    output logic [NUM_CH-1:0] ch_tick,
    output logic [NUM_CH-1:0] ch_busy,
    output logic              cfg_ack,
    output logic              cfg_err
);

    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   TERM_FULL = PW'(PRESCALE - 1);
    localparam logic [CH_W:0]   NUM_CH_W  = (CH_W + 1)'(NUM_CH);

    logic [PW-1:0]    pre_cnt;
    logic [PW-1:0]    term;
    logic [CNT_W-1:0] cnt    [NUM_CH];
    logic [CNT_W-1:0] period [NUM_CH];
    logic [NUM_CH-1:0] done;
    logic [NUM_CH-1:0] mode;
    logic run;
    logic wrap;
    logic cfg_valid;

`ifdef BEAT_FAST_FWD_EN
    localparam logic [PW-1:0] TERM_HALF = PW'(PRESCALE / 2 - 1);
    // >= compare below means a late switch to the short term wraps at once
    assign term = fast_fwd ? TERM_HALF : TERM_FULL;
`else
    assign term = TERM_FULL;
`endif

    assign run       = is_game & ~is_open;
    assign wrap      = (pre_cnt >= term);
    assign cfg_valid = ({1'b0, cfg_ch} < NUM_CH_W);

    always_comb begin
        ch_busy = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_busy[i] = ch_en[i] & (period[i] != '0) & ~done[i];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pre_cnt   <= '0;
            seconds   <= '0;
            base_tick <= 1'b0;
            ch_tick   <= '0;
            cfg_ack   <= 1'b0;
            cfg_err   <= 1'b0;
            done      <= '0;
            mode      <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]    <= '0;
                period[i] <= '0;
            end
        end else begin
            base_tick <= 1'b0;
            ch_tick   <= '0;
            cfg_ack   <= cfg_we & cfg_valid;
            cfg_err   <= cfg_we & ~cfg_valid;

            if (is_open) begin
                pre_cnt <= '0;
                seconds <= '0;
                done    <= '0;
                for (int i = 0; i < NUM_CH; i++) begin
                    cnt[i] <= '0;
                end
            end else if (run) begin
                if (wrap) begin
                    pre_cnt   <= '0;
                    seconds   <= seconds + SEC_W'(1);
                    base_tick <= 1'b1;
                end else begin
                    pre_cnt <= pre_cnt + PW'(1);
                end
                for (int i = 0; i < NUM_CH; i++) begin
                    if (base_tick && ch_en[i] && (period[i] != '0) && !done[i]) begin
                        if (cnt[i] == period[i] - CNT_W'(1)) begin
                            cnt[i]     <= '0;
                            ch_tick[i] <= 1'b1;
                            if (mode[i]) begin
                                done[i] <= 1'b1;
                            end
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                end
            end

            // A config write overrides any expiry on the same channel this edge
            if (cfg_we && cfg_valid) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (cfg_ch == CH_W'(i)) begin
                        period[i]  <= cfg_period;
                        mode[i]    <= cfg_oneshot;
                        cnt[i]     <= '0;
                        done[i]    <= 1'b0;
                        ch_tick[i] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
